or4_resp_checker: RTL and testbench
===================================

Name: or4_resp_checker

Overview:
Synthesizable response-side companion to the 4-input OR stimulus sequence. It drives an exhaustive 4-bit input vector into a device under verification (DUV) and waits a programmable settle time. It then samples the DUV output and compares it against the expected OR of the vector. It reports pass/fail, a mismatch count and the first failing vector, so OR4 variants can be checked on-board without a simulator.

Parameters:
N_IN, 4, number of DUV inputs; the sweep covers 2^N_IN vectors.
SETTLE_CYCLES, 4, cycles each vector is held before sampling; legal range 1..255.

Ports:
i_clk  input  1  single system clock; all logic on rising edge
i_rst  input  1  synchronous, active-high reset
i_start  input  1  one-cycle request to begin a sweep
i_f  input  1  DUV output under check
o_vec  output  N_IN  stimulus vector to DUV; bit N_IN-1 = input a, bit 0 = input d
o_busy  output  1  sweep in progress
o_done  output  1  sweep complete; results valid
o_pass  output  1  high with o_done when zero mismatches
o_err_cnt  output  N_IN+1  mismatch count, 0..2^N_IN
o_fail_valid  output  1  at least one mismatch captured
o_fail_vec  output  N_IN  first vector that mismatched

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0: o_vec, o_busy, o_done, o_pass, o_err_cnt, o_fail_valid, o_fail_vec.
  - Reset has priority over every other input.
  - Reset mid-sweep aborts the sweep; no partial results are retained.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - i_start=1 -> SETTLE.
  - On entry to SETTLE: o_vec=0, settle counter=0, o_busy=1, o_err_cnt=0, o_fail_valid=0, o_fail_vec=0.
- SETTLE:
  - o_vec is held stable and the counter increments each cycle.
  - After SETTLE_CYCLES cycles in SETTLE -> SAMPLE.
- SAMPLE (one cycle):
  - Expected value = reduction OR of o_vec.
  - If i_f differs from expected, o_err_cnt increments.
  - If o_fail_valid=0 on a mismatch, o_fail_vec <= o_vec and o_fail_valid <= 1. Later mismatches never overwrite the capture.
  - If o_vec = all ones -> DONE.
  - Otherwise o_vec <= o_vec+1, counter cleared -> SETTLE.
- DONE:
  - o_busy=0, o_done=1, o_pass = (o_err_cnt==0).
  - Results hold until reset or i_start.
  - i_start=1 in DONE behaves exactly as in IDLE: results are cleared, o_done drops the next cycle and a new sweep begins.
- i_start is ignored while in SETTLE or SAMPLE; there is no restart mid-sweep.
- Latency:
  - Define the edge where i_start is sampled as cycle 0; vector 0 appears on o_vec after that edge.
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - o_done rises after edge 2^N_IN*(SETTLE_CYCLES+1); with defaults, 80 cycles after start.
- Width rules:
  - o_err_cnt is N_IN+1 bits, so the maximum of 2^N_IN cannot overflow; no saturation logic is needed.
  - o_vec never wraps: the sweep terminates at all ones.
  - The settle counter is 8 bits.
- i_f is sampled only in SAMPLE; its value in other states has no effect.
- o_vec changes only on the SAMPLE->SETTLE transition or at sweep start.

Decomposition:
- Package or4_chk_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE);
  - the default N_IN and SETTLE_CYCLES;
  - the settle-counter width constant (8).
- Sub-module settle_timer: a loadable up-counter with clear and enable inputs and a terminal-count output at SETTLE_CYCLES-1. It is instantiated once.
- The FSM, vector register and result registers stay in or4_resp_checker.

Test Plan:
1. Ideal OR model on i_f, defaults, pulse i_start -> o_done rises 80 cycles after start; o_pass=1, o_err_cnt=0, o_fail_valid=0; o_vec steps 0..15, each held 5 cycles.
2. i_f stuck at 0 -> o_done, o_pass=0, o_err_cnt=15, o_fail_valid=1, o_fail_vec=4'b0001.
3. i_f stuck at 1 -> o_err_cnt=1, o_fail_vec=4'b0000, o_pass=0.
4. Inverted OR (NOR) on i_f -> o_err_cnt=16 (5'b10000), o_fail_vec=4'b0000.
5. Reset asserted 30 cycles into a sweep -> next cycle all outputs are 0 and the state is IDLE. A fresh i_start then completes case 1 results exactly.
6. i_start pulsed at cycle 10 of a sweep -> ignored, completion still at cycle 80. i_start pulsed in DONE after case 2 -> o_done=0 and o_err_cnt=0 next cycle, and the new sweep with ideal DUV ends with o_pass=1.

Source files
------------

// File: rtl/or4_chk_pkg.sv
// or4_chk_pkg: shared state encoding and default sizing for the OR4 response checker
package or4_chk_pkg;
  localparam int DEF_N_IN = 4;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
endpackage

// File: rtl/settle_timer.sv
// settle_timer: loadable up-counter flagging the last cycle of a settle window
module settle_timer
  import or4_chk_pkg::*;
#(
  parameter int LIMIT = DEF_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [CNT_W-1:0] d,
  input  logic             en,
  output logic             tc
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (ld) cnt <= d;
    else if (en) cnt <= cnt + 1'b1;
  end
  assign tc = cnt == CNT_W'(LIMIT - 1);
endmodule

// File: rtl/or4_resp_checker.sv
// or4_resp_checker: sweeps every input vector into an OR4 DUV and scores its response
module or4_resp_checker
  import or4_chk_pkg::*;
#(
  parameter int N_IN = DEF_N_IN,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_f,
  output logic [N_IN-1:0] o_vec,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_pass,
  output logic [N_IN:0]   o_err_cnt,
  output logic            o_fail_valid,
  output logic [N_IN-1:0] o_fail_vec
);
  state_t state;
  logic   tc, start_ok, mis, last;
  assign start_ok = i_start && (state == IDLE || state == DONE);
  assign mis      = i_f != (|o_vec);
  assign last     = &o_vec;
  assign o_busy   = state == SETTLE || state == SAMPLE;
  assign o_done   = state == DONE;
  assign o_pass   = o_done && o_err_cnt == '0;
  settle_timer #(.LIMIT(SETTLE_CYCLES)) u_timer (
    .clk(i_clk),
    .rst(i_rst),
    .clr(start_ok || state == SAMPLE),
    .ld (1'b0),
    .d  ('0),
    .en (state == SETTLE && !tc),
    .tc (tc)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      o_vec        <= '0;
      o_err_cnt    <= '0;
      o_fail_valid <= 1'b0;
      o_fail_vec   <= '0;
    end else if (start_ok) begin
      state        <= SETTLE;
      o_vec        <= '0;
      o_err_cnt    <= '0;
      o_fail_valid <= 1'b0;
      o_fail_vec   <= '0;
    end else if (state == SETTLE && tc) begin
      state <= SAMPLE;
    end else if (state == SAMPLE) begin
      o_err_cnt <= o_err_cnt + (N_IN + 1)'(mis);
      if (mis && !o_fail_valid) begin
        o_fail_valid <= 1'b1;
        o_fail_vec   <= o_vec;
      end
      state <= last ? DONE : SETTLE;
      if (!last) o_vec <= o_vec + 1'b1;
    end
  end
endmodule

// File: tb/tb_or4_resp_checker.sv
// tb_or4_resp_checker: table-driven sweeps against modelled DUV variants with a result scoreboard
module tb_or4_resp_checker;
  logic       clk = 0, rst = 1, start = 0, f;
  logic [3:0] vec, fail_vec;
  logic       busy, done, pass, fail_valid;
  logic [4:0] err_cnt;
  int mode = 0, checks = 0, failures = 0;
  typedef struct {
    int mode; int chk_vec; int inj; int err; int pass; int fv; int fvec;
  } vec_t;
  vec_t tbl[5];
  vec_t sb[$];
  always #5 clk = ~clk;
  // mode 0 ideal OR, 1 stuck-0, 2 stuck-1, 3 NOR
  assign f = mode == 0 ? |vec : mode == 1 ? 1'b0 : mode == 2 ? 1'b1 : ~|vec;
  or4_resp_checker dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_f(f), .o_vec(vec), .o_busy(busy),
    .o_done(done), .o_pass(pass), .o_err_cnt(err_cnt), .o_fail_valid(fail_valid),
    .o_fail_vec(fail_vec)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_vec"}, vec, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_cnt, 0);
    chk({tag, "_fv"}, fail_valid, 0);
    chk({tag, "_fvec"}, fail_vec, 0);
  endtask
  task automatic sweep(input int m, input int chk_vec, input int inj);
    vec_t e;
    int cyc = 0;
    bit got = 0;
    mode = m;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_err", err_cnt, 0);
    while (!got && cyc < 300) begin
      if (done) got = 1;
      else begin
        if (chk_vec != 0 && cyc % 5 == 2) chk("vec_step", vec, cyc / 5);
        start = cyc == inj;
        @(negedge clk) cyc++;
      end
    end
    start = 0;
    if (!got) begin
      failures++;
      $display("FAIL done_timeout actual=%0d required=80", cyc);
    end
    chk("done_cycle", cyc, 80);
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = sb.pop_front();
      chk("err_cnt", err_cnt, e.err);
      chk("pass", pass, e.pass);
      chk("fail_valid", fail_valid, e.fv);
      chk("fail_vec", fail_vec, e.fvec);
      repeat (3) @(negedge clk);
      chk("hold_done", done, 1);
      chk("hold_err", err_cnt, e.err);
    end
  endtask
  initial begin
    tbl[0] = '{0, 1, -1, 0, 1, 0, 0};
    tbl[1] = '{1, 0, -1, 15, 0, 1, 1};
    tbl[2] = '{0, 0, 10, 0, 1, 0, 0};
    tbl[3] = '{2, 0, -1, 1, 0, 1, 0};
    tbl[4] = '{3, 0, -1, 16, 0, 1, 0};
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(tbl[i]);
      sweep(tbl[i].mode, tbl[i].chk_vec, tbl[i].inj);
    end
    mode = 0;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    repeat (30) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1;
    @(negedge clk) rst = 0;
    chk_idle("abort");
    repeat (2) @(negedge clk);
    chk("abort_stay_idle", busy, 0);
    sb.push_back(tbl[0]);
    sweep(0, 0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
